// File: rtl/out_capture_fifo_if.sv
// Capture FIFO bus: producer offer side and consumer read side.
// master drives offers and rd_ready; slave is the FIFO.
interface out_capture_fifo_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic [DATA_W:0]   rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        output rd_ready,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        input  rd_ready,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/out_capture_fifo.sv
// Capture FIFO for CPU out_data words tagged with select_out.
// Optional change filter: define OUT_CAPTURE_CHANGE_FILTER_EN.
module out_capture_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    out_capture_fifo_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drop_q, drop_d;

    logic [DATA_W:0] in_word;
    logic            filtered;
    logic            cand;
    logic            pop;
    logic            push;
    logic            drop;
    logic            not_empty;

    assign in_word   = {bus.in_sel, bus.in_data};
    assign not_empty = (count_q != '0);

`ifdef OUT_CAPTURE_CHANGE_FILTER_EN
    logic [DATA_W:0] hist_q;
    logic            hist_vld_q;

    // Remember the last accepted word; valid once anything was pushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
        end else if (push) begin
            hist_q     <= in_word;
            hist_vld_q <= 1'b1;
        end
    end

    assign filtered = hist_vld_q && (in_word == hist_q);
`else
    assign filtered = 1'b0;
`endif

    // Offer/pop qualification; a full FIFO still takes an offer if it pops.
    always_comb begin
        pop  = not_empty && bus.rd_ready;
        cand = bus.in_valid && !filtered;
        push = cand && ((count_q != FULL_CNT) || pop);
        drop = cand && !push;
    end

    // Next-state for pointers, occupancy and overflow bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_ovf) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

    // Control state; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push && reset) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

    // Head is shown combinationally and zeroed when empty.
    always_comb begin
        bus.rd_data  = '0;
        bus.rd_valid = not_empty;
        if (not_empty) begin
            bus.rd_data = mem_q[rd_ptr_q];
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_out_capture_fifo.sv
// Scoreboard bench for out_capture_fifo (DEPTH=8, DATA_W=32).
// Directed offers push expected words; a monitor checks every pop.
module tb_out_capture_fifo;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;

    logic        clk;
    logic        reset;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_ovf;

    int tests;
    int fails;
    logic [DATA_W:0] exp_q[$];

    out_capture_fifo_if #(.DATA_W(DATA_W)) bus ();

    out_capture_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .count   (count),
        .overflow(overflow),
        .drop_cnt(drop_cnt),
        .clr_ovf (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the scoreboard head.
    always @(negedge clk) begin
        if (reset && bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got 0x%0h, expected none",
                         bus.rd_data);
            end else begin
                check("pop_data", 64'(bus.rd_data), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] d, input logic s,
                         input logic acc);
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_valid = 1'b1;
        if (acc) exp_q.push_back({s, d});
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (count == 4'd0) break;
            step();
        end
        bus.rd_ready = 1'b0;
        check("drain_count", 64'(count), 64'd0);
        check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b0;
        clr_ovf      = 1'b0;
        bus.in_data  = 32'h0000_0099;
        bus.in_sel   = 1'b1;
        bus.in_valid = 1'b1;
        bus.rd_ready = 1'b1;
        step();
        step();
        check("rst_count", 64'(count), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        bus.in_valid = 1'b0;
        bus.rd_ready = 1'b0;
        reset        = 1'b1;
        step();

        // First word fall-through latency
        offer(32'h1111_1111, 1'b0, 1'b1);
        check("ffwt_rd_valid", 64'(bus.rd_valid), 64'd1);
        check("ffwt_rd_data", 64'(bus.rd_data), 64'h0_1111_1111);
        check("ffwt_count", 64'(count), 64'd1);
        drain();

        // Ten pushes into eight entries
        for (int i = 0; i < 10; i++) begin
            offer(32'h100 + 32'(i), 1'b0, logic'(i < 8));
        end
        check("fill_count", 64'(count), 64'd8);
        check("fill_overflow", 64'(overflow), 64'd1);
        check("fill_drop_cnt", 64'(drop_cnt), 64'd2);

        // Push into full FIFO while popping
        bus.rd_ready = 1'b1;
        offer(32'hAAAA_AAAA, 1'b0, 1'b1);
        bus.rd_ready = 1'b0;
        check("full_pp_count", 64'(count), 64'd8);
        check("full_pp_drop_cnt", 64'(drop_cnt), 64'd2);
        drain();
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Drop and clear on the same edge, then clear alone
        for (int i = 0; i < 8; i++) begin
            offer(32'h200 + 32'(i), 1'b1, 1'b1);
        end
        clr_ovf = 1'b1;
        offer(32'h300, 1'b0, 1'b0);
        clr_ovf = 1'b0;
        check("drop_clr_overflow", 64'(overflow), 64'd1);
        check("drop_clr_drop_cnt", 64'(drop_cnt), 64'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("clr_overflow", 64'(overflow), 64'd0);
        check("clr_drop_cnt", 64'(drop_cnt), 64'd0);

        // Saturation of the drop counter
        for (int i = 0; i < 260; i++) begin
            offer(32'h300, 1'b0, 1'b0);
        end
        check("sat_drop_cnt", 64'(drop_cnt), 64'd255);
        check("sat_count", 64'(count), 64'd8);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("sat_clr", 64'(drop_cnt), 64'd0);
        drain();

        // Twenty push/pop pairs to wrap both pointers
        offer(32'h3FF, 1'b0, 1'b1);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            offer(32'h400 + 32'(i), logic'(i % 2), 1'b1);
        end
        bus.rd_ready = 1'b0;
        check("wrap_count", 64'(count), 64'd1);
        check("wrap_overflow", 64'(overflow), 64'd0);
        drain();

        // Change filter sequence
        offer(32'h5, 1'b0, 1'b1);
`ifdef OUT_CAPTURE_CHANGE_FILTER_EN
        offer(32'h5, 1'b0, 1'b0);
`else
        offer(32'h5, 1'b0, 1'b1);
`endif
        offer(32'h6, 1'b0, 1'b1);
        offer(32'h5, 1'b0, 1'b1);
`ifdef OUT_CAPTURE_CHANGE_FILTER_EN
        check("filter_count", 64'(count), 64'd3);
`else
        check("filter_count", 64'(count), 64'd4);
`endif
        check("filter_drop_cnt", 64'(drop_cnt), 64'd0);
        drain();

        // Reset mid-operation discards entries and history
        offer(32'h71, 1'b0, 1'b1);
        offer(32'h72, 1'b0, 1'b1);
        offer(32'h77, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("midrst_rd_data", 64'(bus.rd_data), 64'd0);
        exp_q.delete();
        step();
        reset = 1'b1;
        step();
        offer(32'h77, 1'b0, 1'b1);
        check("postrst_count", 64'(count), 64'd1);
        check("postrst_rd_data", 64'(bus.rd_data), 64'h0_0000_0077);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/out_capture_fifo.md
OUT_CAPTURE_FIFO -- requirements
Module: out_capture_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries, power of two, 2..64.
REQ-002 SHALL have parameter DATA_W, default 32, captured data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  DATA_W  CPU out_data word offered for capture.
REQ-006 SHALL have port in_sel  input  1  CPU select_out value, stored as tag with each entry.
REQ-007 SHALL have port in_valid  input  1  offer in_data/in_sel this cycle.
REQ-008 SHALL have port rd_data  output  DATA_W+1  head entry {tag, data}.
REQ-009 SHALL have port rd_valid  output  1  head entry present.
REQ-010 SHALL have port rd_ready  input  1  consumer accepts head this cycle.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  entries stored.
REQ-012 SHALL have port overflow  output  1  sticky: an offer was dropped.
REQ-013 SHALL have port drop_cnt  output  8  dropped offers, saturating.
REQ-014 SHALL have port clr_ovf  input  1  clear overflow and drop_cnt.

Function
REQ-015 SHALL pop the head on a rising edge when rd_valid=1 and rd_ready=1; rd_ready with rd_valid=0 is ignored.
REQ-016 SHALL accept an offer (in_valid=1, not filtered) when count<DEPTH, or when count=DEPTH and a pop occurs on the same edge.
REQ-017 SHALL, on simultaneous push and pop, leave count unchanged and keep FIFO order.
REQ-018 SHALL make an accepted entry visible on rd_data/rd_valid the cycle after its write edge (one-cycle latency, first-word-fall-through).
REQ-019 SHALL drive rd_valid=(count!=0) and drive rd_data from head storage combinationally, forced to all-zero when count=0.
REQ-020 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entry.
REQ-021 SHALL drop an offer that cannot be accepted, set overflow=1 and increment drop_cnt, saturating at 255.
REQ-022 SHALL hold overflow at 1 until clr_ovf=1 at a rising edge, which clears overflow and drop_cnt to 0.
REQ-023 SHALL give a drop precedence over clr_ovf on the same edge: overflow=1, drop_cnt=1.
REQ-024 SHALL keep count within 0..DEPTH at all times.

Reset
REQ-025 SHALL, while reset=0, immediately force pointers=0, count=0, rd_valid=0, rd_data=0, overflow=0, drop_cnt=0, filter history invalid.
REQ-026 SHALL discard all stored entries on reset asserted mid-operation; storage array contents are not reset.
REQ-027 SHALL accept no push or pop on the first rising edge while reset=0; operation resumes on the first edge after reset deasserts.

Configuration
REQ-028 SHALL compile a change filter in with macro OUT_CAPTURE_CHANGE_FILTER_EN.
REQ-029 SHALL, with the macro defined, discard an offer whose {in_sel,in_data} equals the last accepted entry while history is valid; a filtered offer is neither a push nor a drop.
REQ-030 SHALL, with the macro defined, update the history only on an accepted push; history becomes valid on the first accepted push after reset.
REQ-031 SHALL, without the macro, treat every in_valid=1 offer as a push candidate and instantiate no history register.

Verification
REQ-032 SHALL check: reset release, push 0x11111111 sel=0 at edge N -> rd_valid=1, rd_data=0x0_11111111 from cycle N+1, count=1.
REQ-033 SHALL check: DEPTH=8, 10 consecutive distinct pushes, no pops -> count=8, overflow=1, drop_cnt=2, first pop returns push #1.
REQ-034 SHALL check: full FIFO, push 0xAAAAAAAA with rd_ready=1 same edge -> count stays 8, 0xAAAAAAAA is the last of the next 8 pops.
REQ-035 SHALL check: 20 push/pop pairs through DEPTH=8 -> pointers wrap, pop sequence equals push sequence exactly.
REQ-036 SHALL check: drop and clr_ovf on same edge -> overflow=1, drop_cnt=1; clr_ovf alone next edge -> both 0.
REQ-037 SHALL check: macro defined, offers 0x5,0x5,0x6,0x5 sel=0 -> 3 entries 0x5,0x6,0x5, drop_cnt=0; macro undefined -> 4 entries.
